modpoly_stream_reader: RTL and testbench

//  Read-side sequencer for the 13-bit polynomial coefficient RAMs (async-read, sync-write).
//  On start, it walks LEN consecutive read addresses from BASE.
//  It returns each coefficient over a valid/ready stream with a last flag and the coefficient index.
//  It feeds the mult/reduction datapath with one coefficient per cycle when the consumer is ready.

---
 rtl/modpoly_stream_reader.sv | 134 +++++++++++++
 tb/tb_modpoly_stream_reader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/modpoly_stream_reader.sv
// Read-side sequencer for the polynomial coefficient RAMs: walks len addresses from base
// and streams each coefficient out over valid/ready with index and last markers.
module modpoly_stream_reader #(
  parameter int unsigned RAM_WIDTH     = 13,
  parameter int unsigned RAM_ADDR_BITS = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS-1:0] base,
  input  logic [RAM_ADDR_BITS-1:0] len,
  input  logic                     abort,
  output logic [RAM_ADDR_BITS-1:0] read_address,
  input  logic [RAM_WIDTH-1:0]     output_data,
  output logic [RAM_WIDTH-1:0]     coef_data,
  output logic                     coef_valid,
  input  logic                     coef_ready,
  output logic [RAM_ADDR_BITS-1:0] coef_index,
  output logic                     coef_last,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned AW = RAM_ADDR_BITS;
  localparam int unsigned DW = RAM_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_d;

  logic [AW-1:0] addr;
  logic [AW-1:0] rem;
  logic [AW-1:0] idx;

  logic start_c;
  logic zero_job_c;
  logic load_c;
  logic accept_c;
  logic finish_c;

  // The RAM is addressed straight from the address register.
  assign read_address = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and per-cycle control strobes; abort overrides everything.
  always_comb begin
    state_d    = state;
    start_c    = 1'b0;
    zero_job_c = 1'b0;
    load_c     = 1'b0;
    finish_c   = 1'b0;
    accept_c   = coef_valid && coef_ready;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            start_c = 1'b1;
            if (len == '0) begin
              zero_job_c = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          load_c = (!coef_valid || coef_ready) && (rem != '0);
          if (load_c && (rem == AW'(1))) begin
            state_d = FLUSH;
          end
        end
        FLUSH: begin
          if (accept_c) begin
            finish_c = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Job counters and the registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      rem        <= '0;
      idx        <= '0;
      coef_data  <= '0;
      coef_valid <= 1'b0;
      coef_index <= '0;
      coef_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= zero_job_c || finish_c;
      busy <= (state_d != IDLE);
      if (abort) begin
        coef_valid <= 1'b0;
        coef_last  <= 1'b0;
      end else if (start_c) begin
        addr <= base;
        rem  <= len;
        idx  <= '0;
      end else if (load_c) begin
        coef_data  <= DW'(output_data);
        coef_valid <= 1'b1;
        coef_index <= idx;
        coef_last  <= (rem == AW'(1));
        addr       <= addr + AW'(1);
        idx        <= idx + AW'(1);
        rem        <= rem - AW'(1);
      end else if (finish_c) begin
        coef_valid <= 1'b0;
        coef_last  <= 1'b0;
      end else if (accept_c) begin
        coef_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_modpoly_stream_reader.sv
// Directed bench for modpoly_stream_reader with a behavioural async-read coefficient RAM.
module tb_modpoly_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] base;
  logic [10:0] len;
  logic        abort;
  logic [10:0] read_address;
  logic [12:0] output_data;
  logic [12:0] coef_data;
  logic        coef_valid;
  logic        coef_ready;
  logic [10:0] coef_index;
  logic        coef_last;
  logic        busy;
  logic        done;

  logic [12:0] ram [0:2047];

  int n_assert;
  int n_fail;

  modpoly_stream_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base         (base),
    .len          (len),
    .abort        (abort),
    .read_address (read_address),
    .output_data  (output_data),
    .coef_data    (coef_data),
    .coef_valid   (coef_valid),
    .coef_ready   (coef_ready),
    .coef_index   (coef_index),
    .coef_last    (coef_last),
    .busy         (busy),
    .done         (done)
  );

  assign output_data = ram[read_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [10:0] b, input logic [10:0] l);
    base  = b;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int          k;
    int          cyc;
    bit          got_done;
    bit          hold;
    logic [12:0] p_data;
    logic [10:0] p_index;
    logic        p_last;
    logic [10:0] p_addr;

    n_assert = 0;
    n_fail   = 0;
    for (int i = 0; i < 2048; i++) ram[i] = 13'((i * 3) % 4591);

    rst_n      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    base       = '0;
    len        = '0;
    coef_ready = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_valid", 32'(coef_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(read_address), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: full job, consumer always ready
    coef_ready = 1'b1;
    start_job(11'd0, 11'd757);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_valid_lat", 32'(coef_valid), 32'd0);
    chk("t1_addr0", 32'(read_address), 32'd0);
    tick();
    for (int b = 0; b < 757; b++) begin
      chk("t1_valid", 32'(coef_valid), 32'd1);
      chk("t1_index", 32'(coef_index), 32'(b));
      chk("t1_data", 32'(coef_data), 32'(ram[b]));
      chk("t1_last", 32'(coef_last), 32'(b == 756));
      chk("t1_nodone", 32'(done), 32'd0);
      tick();
    end
    chk("t1_valid_end", 32'(coef_valid), 32'd0);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);

    // 2: same job with random backpressure
    coef_ready = 1'b0;
    start_job(11'd0, 11'd757);
    k = 0; cyc = 0; got_done = 1'b0; hold = 1'b0;
    p_data = '0; p_index = '0; p_last = 1'b0; p_addr = '0;
    while (!got_done && cyc < 5000) begin
      if (coef_valid) begin
        chk("t2_index", 32'(coef_index), 32'(k));
        chk("t2_data", 32'(coef_data), 32'(ram[k]));
        chk("t2_last", 32'(coef_last), 32'(k == 756));
        if (hold) begin
          chk("t2_hold_data", 32'(coef_data), 32'(p_data));
          chk("t2_hold_index", 32'(coef_index), 32'(p_index));
          chk("t2_hold_last", 32'(coef_last), 32'(p_last));
          chk("t2_hold_addr", 32'(read_address), 32'(p_addr));
        end
      end
      if (done) begin
        got_done = 1'b1;
      end else begin
        coef_ready = 1'($urandom_range(0, 1));
        hold    = coef_valid && !coef_ready;
        p_data  = coef_data;
        p_index = coef_index;
        p_last  = coef_last;
        p_addr  = read_address;
        if (coef_valid && coef_ready) k++;
        tick();
        cyc++;
      end
    end
    chk("t2_got_done", 32'(got_done), 32'd1);
    chk("t2_beats", 32'(k), 32'd757);
    chk("t2_valid_end", 32'(coef_valid), 32'd0);

    // 3: address wrap from the top of the RAM
    coef_ready = 1'b1;
    tick();
    start_job(11'd2040, 11'd16);
    chk("t3_addr_start", 32'(read_address), 32'd2040);
    tick();
    for (int b = 0; b < 16; b++) begin
      chk("t3_index", 32'(coef_index), 32'(b));
      chk("t3_data", 32'(coef_data), 32'(ram[(2040 + b) % 2048]));
      chk("t3_addr", 32'(read_address), 32'((2041 + b) % 2048));
      chk("t3_last", 32'(coef_last), 32'(b == 15));
      tick();
    end
    chk("t3_done", 32'(done), 32'd1);

    // 4: zero-length job
    tick();
    start_job(11'd7, 11'd0);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_valid", 32'(coef_valid), 32'd0);
    tick();
    chk("t4_done_pulse", 32'(done), 32'd0);
    chk("t4_valid2", 32'(coef_valid), 32'd0);
    chk("t4_busy2", 32'(busy), 32'd0);

    // 5: abort at beat 100, then a short job from 1024
    start_job(11'd0, 11'd757);
    tick();
    for (int b = 0; b < 100; b++) tick();
    chk("t5_pre_index", 32'(coef_index), 32'd100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_valid", 32'(coef_valid), 32'd0);
    chk("t5_last", 32'(coef_last), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_hold_index", 32'(coef_index), 32'd100);
    chk("t5_hold_data", 32'(coef_data), 32'(ram[100]));
    tick();
    chk("t5_done2", 32'(done), 32'd0);
    start_job(11'd1024, 11'd4);
    tick();
    for (int b = 0; b < 4; b++) begin
      chk("t5_new_index", 32'(coef_index), 32'(b));
      chk("t5_new_data", 32'(coef_data), 32'(ram[1024 + b]));
      chk("t5_new_last", 32'(coef_last), 32'(b == 3));
      tick();
    end
    chk("t5_new_done", 32'(done), 32'd1);

    // 6: restart mid-job is ignored, then async reset mid-job
    tick();
    start_job(11'd0, 11'd757);
    tick();
    for (int b = 0; b < 10; b++) tick();
    chk("t6_index10", 32'(coef_index), 32'd10);
    base  = 11'd500;
    len   = 11'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_index11", 32'(coef_index), 32'd11);
    chk("t6_data11", 32'(coef_data), 32'(ram[11]));
    chk("t6_addr", 32'(read_address), 32'd12);
    chk("t6_busy", 32'(busy), 32'd1);
    for (int b = 0; b < 9; b++) tick();
    chk("t6_index20", 32'(coef_index), 32'd20);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(coef_valid), 32'd0);
    chk("t6_rst_data", 32'(coef_data), 32'd0);
    chk("t6_rst_index", 32'(coef_index), 32'd0);
    chk("t6_rst_last", 32'(coef_last), 32'd0);
    chk("t6_rst_addr", 32'(read_address), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("t6_idle_valid", 32'(coef_valid), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);

    // start and abort together in IDLE: abort wins
    base  = 11'd5;
    len   = 11'd3;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t6_sa_busy", 32'(busy), 32'd0);
    chk("t6_sa_addr", 32'(read_address), 32'd0);
    chk("t6_sa_done", 32'(done), 32'd0);
    tick();
    chk("t6_sa_valid", 32'(coef_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
